// File: rtl/window_min_max_tracker.sv
// Windowed min/max tracker: collects WINDOW unsigned samples, then
// reports min, max and range on a held valid/ready output.
module window_min_max_tracker #(
   parameter int WIDTH  = 4,
   parameter int WINDOW = 8,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_min,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_range,
   output logic             new_min,
   output logic             new_max
);

   typedef enum logic [1:0] {
      FIRST  = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] min_q;
   logic [WIDTH-1:0] max_q;
   logic [WIDTH-1:0] min_nx;
   logic [WIDTH-1:0] max_nx;
   logic             accept;
   logic             lower;
   logic             higher;
   logic             last;

   assign in_ready  = (state != REPORT);
   assign out_valid = (state == REPORT);

   // clear wins over any handshake, so a sample on a clear cycle is dropped
   assign accept = in_valid & in_ready & ~clear;
   assign lower  = (in_data < min_q);
   assign higher = (in_data > max_q);
   assign min_nx = lower  ? in_data : min_q;
   assign max_nx = higher ? in_data : max_q;
   assign last   = (count == CNT_W'(WINDOW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FIRST;
         count     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         out_min   <= '0;
         out_max   <= '0;
         out_range <= '0;
         new_min   <= 1'b0;
         new_max   <= 1'b0;
      end else begin
         new_min <= 1'b0;
         new_max <= 1'b0;
         if (clear) begin
            state <= FIRST;
            count <= '0;
         end else begin
            unique case (state)
               FIRST: begin
                  if (accept) begin
                     min_q <= in_data;
                     max_q <= in_data;
                     count <= CNT_W'(1);
                     state <= ACCUM;
                  end
               end
               ACCUM: begin
                  if (accept) begin
                     min_q   <= min_nx;
                     max_q   <= max_nx;
                     new_min <= lower;
                     new_max <= higher;
                     count   <= count + CNT_W'(1);
                     if (last) begin
                        state     <= REPORT;
                        out_min   <= min_nx;
                        out_max   <= max_nx;
                        out_range <= max_nx - min_nx;
                     end
                  end
               end
               REPORT: begin
                  if (out_ready) begin
                     state <= FIRST;
                     count <= '0;
                  end
               end
               default: begin
                  state <= FIRST;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_window_min_max_tracker.sv
// Directed bench for window_min_max_tracker with WINDOW = 4.
module tb_window_min_max_tracker;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_min;
   logic [3:0] out_max;
   logic [3:0] out_range;
   logic       new_min;
   logic       new_max;

   int checks;
   int fails;

   window_min_max_tracker #(
      .WIDTH (4),
      .WINDOW(4),
      .CNT_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_min  (out_min),
      .out_max  (out_max),
      .out_range(out_range),
      .new_min  (new_min),
      .new_max  (new_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 4'd5;
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_out_valid got %0b want 0", out_valid);
      end
      checks++;
      if ({out_min, out_max, out_range} !== 12'h000) begin
         fails++;
         $display("FAIL reset_outs got %h %h %h want 0 0 0",
                  out_min, out_max, out_range);
      end
      checks++;
      if ({new_min, new_max} !== 2'b00) begin
         fails++;
         $display("FAIL reset_strobes got %b want 00", {new_min, new_max});
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready got %0b want 1", in_ready);
      end
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] s [4];
      logic [1:0] stb [4];
      s = '{4'd5, 4'd2, 4'd9, 4'd2};
      stb = '{2'b00, 2'b10, 2'b01, 2'b00};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = s[i];
         tick();
         checks++;
         if ({new_min, new_max} !== stb[i]) begin
            fails++;
            $display("FAIL basic_strobe%0d got %b want %b",
                     i, {new_min, new_max}, stb[i]);
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd2, 4'd9, 4'd7}) begin
         fails++;
         $display("FAIL basic_result got v%0b %0d %0d %0d want v1 2 9 7",
                  out_valid, out_min, out_max, out_range);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_held_one got v%0b r%0b want v0 r1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_extremes();
      logic [3:0] s [4];
      int strobes;
      s = '{4'd15, 4'd0, 4'd0, 4'd15};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = s[i];
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd0, 4'd15, 4'd15}) begin
         fails++;
         $display("FAIL extremes_result got v%0b %0d %0d %0d want v1 0 15 15",
                  out_valid, out_min, out_max, out_range);
      end
      tick();
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 4'd7;
         tick();
         strobes += int'(new_min) + int'(new_max);
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd7, 4'd7, 4'd0}) begin
         fails++;
         $display("FAIL equal_result got v%0b %0d %0d %0d want v1 7 7 0",
                  out_valid, out_min, out_max, out_range);
      end
      checks++;
      if (strobes !== 0) begin
         fails++;
         $display("FAIL equal_strobes got %0d want 0", strobes);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [3:0] s [4];
      int bad;
      s = '{4'd1, 4'd4, 4'd3, 4'd2};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = s[i];
         tick();
      end
      in_data = 4'd10;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             {out_min, out_max, out_range} !== {4'd1, 4'd4, 4'd3})
            bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL bp_stall got %0d bad cycles want 0", bad);
      end
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd1, 4'd4, 4'd3}) begin
         fails++;
         $display("FAIL bp_hold got v%0b %0d %0d %0d want v1 1 4 3",
                  out_valid, out_min, out_max, out_range);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release got v%0b r%0b want v0 r1",
                  out_valid, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         in_data = 4'(10 + i);
         tick();
         if (i == 2) begin
            checks++;
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL bp_early got v%0b want 0", out_valid);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd10, 4'd13, 4'd3}) begin
         fails++;
         $display("FAIL bp_next got v%0b %0d %0d %0d want v1 10 13 3",
                  out_valid, out_min, out_max, out_range);
      end
      tick();
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 4'd3;
      tick();
      in_data = 4'd8;
      tick();
      clear = 1'b1;
      in_data = 4'd0;
      tick();
      clear = 1'b0;
      checks++;
      if ({out_valid, new_min, new_max} !== 3'b000) begin
         fails++;
         $display("FAIL clear_cycle got %b want 000",
                  {out_valid, new_min, new_max});
      end
      for (int i = 0; i < 4; i++) begin
         in_data = 4'd6;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== {1'b1, 4'd6, 4'd6, 4'd0}) begin
         fails++;
         $display("FAIL clear_result got v%0b %0d %0d %0d want v1 6 6 0",
                  out_valid, out_min, out_max, out_range);
      end
      clear = 1'b1;
      in_valid = 1'b1;
      in_data = 4'd1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL clear_handshake got v%0b r%0b want v0 r1",
                  out_valid, in_ready);
      end
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 4'(i + 2);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         fails++;
         $display("FAIL async_pre got v%0b want 1", out_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_min, out_max, out_range} !== 13'h0) begin
         fails++;
         $display("FAIL async_drop got v%0b %0d %0d %0d want v0 0 0 0",
                  out_valid, out_min, out_max, out_range);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_in_ready got %0b want 1", in_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL async_after got v%0b want 0", out_valid);
      end
   endtask

   initial begin
      checks = 0;
      fails = 0;
      clear = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_extremes();
      test_backpressure();
      test_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
